// File: rtl/exp_engine_arbiter.sv
// Round-robin arbiter/sequencer sharing one series-evaluation engine among N requesters.
// Optional watchdog abort compiled in with `define ARB_TIMEOUT_EN.
module exp_engine_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] x_in,
  output logic [N-1:0]   gnt,
  output logic           eng_start,
  output logic [W-1:0]   eng_x,
  input  logic           eng_done,
  input  logic [W-1:0]   eng_result,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_data,
  output logic           rsp_err
);

  localparam int PW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_RESP} state_t;

  state_t         r_state, w_state_nx;
  logic [PW-1:0]  r_ptr, w_ptr_nx;
  logic [PW-1:0]  r_win, w_win_nx;
  logic [PW-1:0]  w_sel;
  logic           w_found;
  logic [N-1:0]   r_gnt, w_gnt_nx;
  logic           r_eng_start, w_eng_start_nx;
  logic [W-1:0]   r_eng_x, w_eng_x_nx;
  logic [N-1:0]   r_rsp_valid, w_rsp_valid_nx;
  logic [W-1:0]   r_rsp_data, w_rsp_data_nx;
  logic           r_rsp_err, w_rsp_err_nx;
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]  r_wdog, w_wdog_nx;
`endif

  // First requesting index at or after the pointer, wrapping mod N
  always_comb begin
    w_found = 1'b0;
    w_sel   = {PW{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (!w_found && req[(int'(r_ptr) + i) % N]) begin
        w_found = 1'b1;
        w_sel   = PW'((int'(r_ptr) + i) % N);
      end
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_ptr_nx       = r_ptr;
    w_win_nx       = r_win;
    w_gnt_nx       = r_gnt;
    w_eng_start_nx = 1'b0;
    w_eng_x_nx     = r_eng_x;
    w_rsp_valid_nx = {N{1'b0}};
    w_rsp_data_nx  = r_rsp_data;
    w_rsp_err_nx   = r_rsp_err;
`ifdef ARB_TIMEOUT_EN
    w_wdog_nx      = r_wdog;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nx     = S_START;
          w_win_nx       = w_sel;
          w_gnt_nx       = {{(N-1){1'b0}}, 1'b1} << w_sel;
          w_eng_start_nx = 1'b1;
          w_eng_x_nx     = x_in[w_sel*W +: W];
        end else begin
          w_state_nx     = S_IDLE;
        end
      end
      S_START: begin
        w_state_nx = S_BUSY;
`ifdef ARB_TIMEOUT_EN
        w_wdog_nx  = {CW{1'b0}};
`endif
      end
      S_BUSY: begin
        if (eng_done) begin
          w_state_nx     = S_RESP;
          w_rsp_valid_nx = r_gnt;
          w_rsp_data_nx  = eng_result;
          w_rsp_err_nx   = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (r_wdog == CW'(TIMEOUT - 1)) begin
          w_state_nx     = S_RESP;
          w_rsp_valid_nx = r_gnt;
          w_rsp_data_nx  = {W{1'b0}};
          w_rsp_err_nx   = 1'b1;
        end else begin
          w_wdog_nx      = r_wdog + CW'(1);
        end
`else
        else begin
          w_state_nx     = S_BUSY;
        end
`endif
      end
      S_RESP: begin
        w_state_nx = S_IDLE;
        w_gnt_nx   = {N{1'b0}};
        w_ptr_nx   = (r_win == PW'(N - 1)) ? {PW{1'b0}} : r_win + PW'(1);
      end
      default: begin
        w_state_nx = S_IDLE;
        w_gnt_nx   = {N{1'b0}};
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= {PW{1'b0}};
      r_win       <= {PW{1'b0}};
      r_gnt       <= {N{1'b0}};
      r_eng_start <= 1'b0;
      r_eng_x     <= {W{1'b0}};
      r_rsp_valid <= {N{1'b0}};
      r_rsp_data  <= {W{1'b0}};
      r_rsp_err   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_wdog      <= {CW{1'b0}};
`endif
    end else begin
      r_state     <= w_state_nx;
      r_ptr       <= w_ptr_nx;
      r_win       <= w_win_nx;
      r_gnt       <= w_gnt_nx;
      r_eng_start <= w_eng_start_nx;
      r_eng_x     <= w_eng_x_nx;
      r_rsp_valid <= w_rsp_valid_nx;
      r_rsp_data  <= w_rsp_data_nx;
      r_rsp_err   <= w_rsp_err_nx;
`ifdef ARB_TIMEOUT_EN
      r_wdog      <= w_wdog_nx;
`endif
    end
  end

  assign gnt       = r_gnt;
  assign eng_start = r_eng_start;
  assign eng_x     = r_eng_x;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

endmodule
